// File: rtl/timer_pkg.sv
// Shared encodings for the WIDTH-bit timer: clock selects, waveform modes, flag bit positions.
package timer_pkg;

    localparam int unsigned PRESCALE_W = 10;

    localparam int unsigned TOV_BIT  = 0;
    localparam int unsigned OCF_BASE = 1;

    typedef enum logic [2:0] {
        CS_STOP    = 3'd0,
        CS_DIV1    = 3'd1,
        CS_DIV8    = 3'd2,
        CS_DIV64   = 3'd3,
        CS_DIV256  = 3'd4,
        CS_DIV1024 = 3'd5,
        CS_STOP6   = 3'd6,
        CS_STOP7   = 3'd7
    } cs_e;

    typedef enum logic [1:0] {
        WGM_NORMAL = 2'd0,
        WGM_CTC    = 2'd1,
        WGM_PWM    = 2'd2,
        WGM_RSVD   = 2'd3
    } wgm_e;

    typedef struct packed {
        logic [2:0] rsvd;
        wgm_e       wgm;
        cs_e        cs;
    } tccr_t;

    // Prescaler bits that must all be ones for a tick; zero mask means no divided tick.
    function automatic logic [PRESCALE_W-1:0] presc_mask(input cs_e cs);
        case (cs)
            CS_DIV8:    presc_mask = PRESCALE_W'(10'h007);
            CS_DIV64:   presc_mask = PRESCALE_W'(10'h03F);
            CS_DIV256:  presc_mask = PRESCALE_W'(10'h0FF);
            CS_DIV1024: presc_mask = PRESCALE_W'(10'h3FF);
            default:    presc_mask = '0;
        endcase
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 10-bit prescaler producing a one-cycle count-enable tick (never a clock).
module timer_prescaler
    import timer_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  cs_e  cs_i,
    output logic tick_c_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [PRESCALE_W-1:0] mask_c;

    // Next count: restart from zero whenever the clock select is rewritten.
    always_comb begin
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick decode: /1 every cycle, divided modes when the selected low bits are all ones.
    always_comb begin
        mask_c   = presc_mask(cs_i);
        tick_c_o = 1'b0;
        if (cs_i == CS_DIV1) begin
            tick_c_o = 1'b1;
        end else if (mask_c != '0) begin
            tick_c_o = ((cnt_q & mask_c) == mask_c);
        end
    end

endmodule

// File: rtl/timer_nbit_pwm.sv
// WIDTH-bit timer with NUM_CMP compare channels, normal/CTC modes and optional fast PWM.
// Fast PWM (WGM=2) with buffered OCR is built only when TIMER_PWM_EN is defined.
module timer_nbit_pwm
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_CMP = 1
)
(
    input  logic                     sysClock,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         TCNT_data,
    input  logic                     TCNT_write_enable,
    input  logic [WIDTH*NUM_CMP-1:0] OCR_data,
    input  logic [NUM_CMP-1:0]       OCR_write_enable,
    input  logic [7:0]               TCCR_input,
    input  logic                     TCCR_write_enable,
    input  logic [NUM_CMP:0]         TIMSK_input,
    input  logic                     TIMSK_write_enable,
    input  logic [NUM_CMP:0]         TIFR_clear,
    input  logic                     TIFR_write_enable,
    output logic [WIDTH-1:0]         TCNT_output,
    output logic [7:0]               TCCR_output,
    output logic [WIDTH*NUM_CMP-1:0] OCR_output,
    output logic [NUM_CMP:0]         TIMSK_output,
    output logic [NUM_CMP:0]         TIFR_output,
    output logic [NUM_CMP:0]         irq,
    output logic [NUM_CMP-1:0]       oc_out
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    typedef logic [NUM_CMP-1:0][WIDTH-1:0] ocr_vec_t;

    tccr_t              tccr_q, tccr_d;
    logic [NUM_CMP:0]   timsk_q, timsk_d;
    logic [NUM_CMP:0]   tifr_q, tifr_d;
    logic [NUM_CMP:0]   flag_set;
    ocr_vec_t           ocr_buf_q, ocr_buf_d;
    ocr_vec_t           ocr_act_c;
    logic [WIDTH-1:0]   tcnt_q, tcnt_d;
    logic               tick_c;
    logic               ctc_mode;
    logic               tccr_rsvd_unused;

    assign tccr_rsvd_unused = ^TCCR_input[7:5];
    assign ctc_mode         = (tccr_q.wgm == WGM_CTC);

    timer_prescaler u_prescaler (
        .clk_i    (sysClock),
        .rst_i    (rst),
        .clear_i  (TCCR_write_enable),
        .cs_i     (tccr_q.cs),
        .tick_c_o (tick_c)
    );

`ifdef TIMER_PWM_EN
    ocr_vec_t           ocr_act_q, ocr_act_d;
    logic [NUM_CMP-1:0] oc_q, oc_d;
    logic               pwm_mode;

    assign pwm_mode  = (tccr_q.wgm == WGM_PWM);
    // In PWM the compare value is the double-buffered copy; otherwise the buffer directly.
    assign ocr_act_c = pwm_mode ? ocr_act_q : ocr_buf_q;
    assign oc_out    = oc_q;
`else
    assign ocr_act_c = ocr_buf_q;
    assign oc_out    = '0;
`endif

    // Register writes, counter/compare/mode next-state and flag updates.
    always_comb begin
        tccr_d    = tccr_q;
        timsk_d   = timsk_q;
        ocr_buf_d = ocr_buf_q;
        tcnt_d    = tcnt_q;
        flag_set  = '0;

        if (TCCR_write_enable) begin
            tccr_d.rsvd = '0;
            tccr_d.wgm  = wgm_e'(TCCR_input[4:3]);
            tccr_d.cs   = cs_e'(TCCR_input[2:0]);
        end
        if (TIMSK_write_enable) begin
            timsk_d = TIMSK_input;
        end
        for (int unsigned i = 0; i < NUM_CMP; i++) begin
            if (OCR_write_enable[i]) begin
                ocr_buf_d[i] = OCR_data[i*WIDTH +: WIDTH];
            end
        end

`ifdef TIMER_PWM_EN
        // Outside PWM the active copy follows the buffer so PWM entry starts from it.
        ocr_act_d = pwm_mode ? ocr_act_q : ocr_buf_d;
        oc_d      = pwm_mode ? oc_q : '0;
`endif

        if (TCNT_write_enable) begin
            tcnt_d = TCNT_data;
        end else if (tick_c) begin
            if (ctc_mode && (tcnt_q == ocr_act_c[0])) begin
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + WIDTH'(1);
                if (tcnt_q == CNT_MAX) begin
                    flag_set[TOV_BIT] = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                if (tcnt_q == ocr_act_c[i]) begin
                    flag_set[OCF_BASE + i] = 1'b1;
                end
            end
`ifdef TIMER_PWM_EN
            if (pwm_mode) begin
                if (tcnt_q == CNT_MAX) begin
                    ocr_act_d = ocr_buf_q;
                end
                for (int unsigned i = 0; i < NUM_CMP; i++) begin
                    oc_d[i] = (tcnt_d < ocr_act_d[i]);
                end
            end
`endif
        end

        // Hardware set wins over a same-cycle software clear.
        tifr_d = (tifr_q & ~(TIFR_write_enable ? TIFR_clear : '0)) | flag_set;
    end

    // State registers.
    always_ff @(posedge sysClock) begin
        if (rst) begin
            tccr_q    <= '0;
            timsk_q   <= '0;
            tifr_q    <= '0;
            ocr_buf_q <= '0;
            tcnt_q    <= '0;
`ifdef TIMER_PWM_EN
            ocr_act_q <= '0;
            oc_q      <= '0;
`endif
        end else begin
            tccr_q    <= tccr_d;
            timsk_q   <= timsk_d;
            tifr_q    <= tifr_d;
            ocr_buf_q <= ocr_buf_d;
            tcnt_q    <= tcnt_d;
`ifdef TIMER_PWM_EN
            ocr_act_q <= ocr_act_d;
            oc_q      <= oc_d;
`endif
        end
    end

    assign TCNT_output  = tcnt_q;
    assign TCCR_output  = tccr_q;
    assign OCR_output   = ocr_buf_q;
    assign TIMSK_output = timsk_q;
    assign TIFR_output  = tifr_q;
    assign irq          = tifr_q & timsk_q;

endmodule

// File: tb/tb_timer_nbit_pwm.sv
// Directed bench for timer_nbit_pwm (WIDTH=8, NUM_CMP=2).
module tb_timer_nbit_pwm;

    localparam int unsigned W  = 8;
    localparam int unsigned NC = 2;

    logic            clk;
    logic            rst;
    logic [W-1:0]    tcnt_data;
    logic            tcnt_we;
    logic [W*NC-1:0] ocr_data;
    logic [NC-1:0]   ocr_we;
    logic [7:0]      tccr_in;
    logic            tccr_we;
    logic [NC:0]     timsk_in;
    logic            timsk_we;
    logic [NC:0]     tifr_clr;
    logic            tifr_we;
    logic [W-1:0]    tcnt_o;
    logic [7:0]      tccr_o;
    logic [W*NC-1:0] ocr_o;
    logic [NC:0]     timsk_o;
    logic [NC:0]     tifr_o;
    logic [NC:0]     irq;
    logic [NC-1:0]   oc_out;

    int vectors = 0;
    int errors  = 0;
    int hi0;
    int hi1;

    timer_nbit_pwm #(.WIDTH(W), .NUM_CMP(NC)) dut (
        .sysClock           (clk),
        .rst                (rst),
        .TCNT_data          (tcnt_data),
        .TCNT_write_enable  (tcnt_we),
        .OCR_data           (ocr_data),
        .OCR_write_enable   (ocr_we),
        .TCCR_input         (tccr_in),
        .TCCR_write_enable  (tccr_we),
        .TIMSK_input        (timsk_in),
        .TIMSK_write_enable (timsk_we),
        .TIFR_clear         (tifr_clr),
        .TIFR_write_enable  (tifr_we),
        .TCNT_output        (tcnt_o),
        .TCCR_output        (tccr_o),
        .OCR_output         (ocr_o),
        .TIMSK_output       (timsk_o),
        .TIFR_output        (tifr_o),
        .irq                (irq),
        .oc_out             (oc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr_tccr(input logic [7:0] v);
        tccr_in = v; tccr_we = 1'b1;
        step();
        tccr_we = 1'b0;
    endtask

    task automatic wr_tcnt(input logic [W-1:0] v);
        tcnt_data = v; tcnt_we = 1'b1;
        step();
        tcnt_we = 1'b0;
    endtask

    task automatic wr_ocr(input int ch, input logic [W-1:0] v);
        ocr_data[ch*W +: W] = v;
        ocr_we = '0;
        ocr_we[ch] = 1'b1;
        step();
        ocr_we = '0;
    endtask

    task automatic wr_timsk(input logic [NC:0] v);
        timsk_in = v; timsk_we = 1'b1;
        step();
        timsk_we = 1'b0;
    endtask

    task automatic div_check(input logic [7:0] cs, input int div, input string tag);
        do_reset();
        wr_tccr(cs);
        repeat (div - 1) step();
        chk({tag, "_before"}, 32'(tcnt_o), 32'h0);
        step();
        chk({tag, "_first"}, 32'(tcnt_o), 32'h1);
    endtask

    initial begin
        rst = 1'b1; tcnt_data = '0; tcnt_we = 1'b0; ocr_data = '0; ocr_we = '0;
        tccr_in = '0; tccr_we = 1'b0; timsk_in = '0; timsk_we = 1'b0;
        tifr_clr = '0; tifr_we = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tcnt", 32'(tcnt_o), 32'h0);
        chk("rst_tccr", 32'(tccr_o), 32'h0);
        chk("rst_tifr", 32'(tifr_o), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_oc", 32'(oc_out), 32'h0);

        // Normal mode overflow with TOIE
        wr_ocr(0, 8'h80);
        wr_ocr(1, 8'h80);
        wr_timsk(3'b001);
        chk("timsk", 32'(timsk_o), 32'h1);
        wr_tccr(8'hE1);
        chk("tccr_rsvd", 32'(tccr_o), 32'h01);
        chk("stopped_tcnt", 32'(tcnt_o), 32'h0);
        wr_tcnt(8'hFE);
        chk("preload", 32'(tcnt_o), 32'hFE);
        chk("preload_irq", 32'(irq), 32'h0);
        step();
        chk("max", 32'(tcnt_o), 32'hFF);
        chk("max_tifr", 32'(tifr_o), 32'h0);
        step();
        chk("wrap", 32'(tcnt_o), 32'h00);
        chk("tov", 32'(tifr_o), 32'h1);
        chk("tov_irq", 32'(irq), 32'h1);
        tifr_clr = 3'b001; tifr_we = 1'b1;
        step();
        tifr_we = 1'b0;
        chk("clr_tcnt", 32'(tcnt_o), 32'h01);
        chk("clr_tifr", 32'(tifr_o), 32'h0);
        chk("clr_irq", 32'(irq), 32'h0);

        // Set beats clear in the same cycle
        wr_tcnt(8'hFE);
        step();
        tifr_clr = 3'b001; tifr_we = 1'b1;
        step();
        chk("setclr_tcnt", 32'(tcnt_o), 32'h00);
        chk("setclr_tov", 32'(tifr_o), 32'h1);
        step();
        tifr_we = 1'b0;
        chk("clr2_tifr", 32'(tifr_o), 32'h0);
        chk("clr2_irq", 32'(irq), 32'h0);

        // /8 prescale from reset, then stop mid-count
        do_reset();
        wr_tccr(8'h02);
        chk("div8_n0", 32'(tcnt_o), 32'h0);
        for (int n = 1; n <= 20; n++) begin
            step();
            chk("div8", 32'(tcnt_o), 32'(n / 8));
        end
        wr_tccr(8'h00);
        chk("div8_stop", 32'(tcnt_o), 32'h2);
        repeat (20) step();
        chk("div8_frozen", 32'(tcnt_o), 32'h2);

        // Other divided selects and reserved stop code
        div_check(8'h03, 64, "div64");
        div_check(8'h04, 256, "div256");
        div_check(8'h05, 1024, "div1024");
        do_reset();
        wr_tccr(8'h06);
        repeat (30) step();
        chk("cs6_stop", 32'(tcnt_o), 32'h0);

        // CTC with TOP=5; channel 1 left at 0 matches TCNT==0
        do_reset();
        wr_ocr(0, 8'h05);
        chk("ocr_out", 32'(ocr_o), 32'h0005);
        wr_tccr(8'h09);
        chk("ctc_n0", 32'(tcnt_o), 32'h0);
        for (int n = 1; n <= 14; n++) begin
            step();
            chk("ctc_tcnt", 32'(tcnt_o), 32'(n % 6));
            chk("ctc_tifr", 32'(tifr_o), {29'h0, (n >= 1), (n >= 6), 1'b0});
        end
        tifr_clr = 3'b110; tifr_we = 1'b1;
        step();
        tifr_we = 1'b0;
        chk("ctc_clr", 32'(tifr_o), 32'h0);
        repeat (3) step();
        chk("ctc_top_tcnt", 32'(tcnt_o), 32'h0);
        chk("ctc_top_ocf", 32'(tifr_o), 32'h2);

        // TCNT write beats tick and suppresses compare
        do_reset();
        wr_ocr(0, 8'h10);
        wr_ocr(1, 8'h80);
        wr_tccr(8'h01);
        wr_tcnt(8'h10);
        chk("wr_tcnt1", 32'(tcnt_o), 32'h10);
        wr_tcnt(8'h10);
        chk("wr_tcnt2", 32'(tcnt_o), 32'h10);
        chk("wr_no_ocf", 32'(tifr_o), 32'h0);
        step();
        chk("wr_next", 32'(tcnt_o), 32'h11);
        chk("wr_ocf0", 32'(tifr_o), 32'h2);
        wr_ocr(1, 8'h14);
        step();
        step();
        chk("ch1_pre", 32'(tifr_o), 32'h2);
        step();
        chk("ch1_tcnt", 32'(tcnt_o), 32'h15);
        chk("ch1_ocf", 32'(tifr_o), 32'h6);
        chk("ch1_irq_masked", 32'(irq), 32'h0);
        wr_timsk(3'b100);
        chk("ch1_irq", 32'(irq), 32'h4);

`ifdef TIMER_PWM_EN
        // Fast PWM: duty 64/256, channel 1 OCR=0 stays low, buffered OCR update
        do_reset();
        wr_ocr(0, 8'd64);
        wr_tccr(8'h11);
        hi0 = 0; hi1 = 0;
        repeat (256) begin
            step();
            hi0 += int'(oc_out[0]);
            hi1 += int'(oc_out[1]);
        end
        chk("pwm_duty64", 32'(hi0), 32'd64);
        chk("pwm_ocr0_low", 32'(hi1), 32'd0);
        chk("pwm_wrap_tcnt", 32'(tcnt_o), 32'h0);
        repeat (10) step();
        wr_ocr(0, 8'd192);
        repeat (89) step();
        chk("pwm_buf_tcnt", 32'(tcnt_o), 32'd100);
        chk("pwm_buf_visible", 32'(ocr_o[7:0]), 32'd192);
        chk("pwm_old_active", 32'(oc_out[0]), 32'h0);
        repeat (256) step();
        chk("pwm_new_active", 32'(oc_out[0]), 32'h1);
        hi0 = 0;
        repeat (256) begin
            step();
            hi0 += int'(oc_out[0]);
        end
        chk("pwm_duty192", 32'(hi0), 32'd192);
`else
        // WGM=2 without PWM support counts as normal mode
        do_reset();
        wr_tccr(8'h11);
        repeat (5) step();
        chk("wgm2_tcnt", 32'(tcnt_o), 32'h5);
        chk("wgm2_oc", 32'(oc_out), 32'h0);
        wr_tcnt(8'hFF);
        step();
        chk("wgm2_wrap", 32'(tcnt_o), 32'h0);
        chk("wgm2_tov", 32'(tifr_o[0]), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
